// File: rtl/wheel_pulse_gen.sv
// Wheel-sensor emulator: emits a burst of clean PULSE ticks (HIGH_CYCLES high, >=2 low) at period max(PERIOD, HIGH_CYCLES+2).
// START->PULSE latency 1 cycle; START ignored while BUSY; optional SENT_CNT output via `WHEEL_PULSE_GEN_SENT_CNT_EN.
module wheel_pulse_gen #(
  parameter int PERIOD_W    = 16,
  parameter int NUM_W       = 16,
  parameter int HIGH_CYCLES = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic                ABORT,
  input  logic [PERIOD_W-1:0] PERIOD,
  input  logic [NUM_W-1:0]    NUM_PULSES,
  output logic                PULSE,
  output logic                BUSY,
  output logic                DONE
`ifdef WHEEL_PULSE_GEN_SENT_CNT_EN
  ,
  output logic [NUM_W-1:0]    SENT_CNT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(HIGH_CYCLES + 2);
  localparam logic [PERIOD_W-1:0] HIGH_LAST  = PERIOD_W'(HIGH_CYCLES - 1);

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [NUM_W-1:0]    rem_q, rem_d;
  logic                pulse_q, pulse_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PERIOD_W-1:0] eff_period;
`ifdef WHEEL_PULSE_GEN_SENT_CNT_EN
  logic [NUM_W-1:0]    sent_q, sent_d;
`endif

  // Clamping guarantees a low phase of at least two cycles before every rise.
  assign eff_period = (PERIOD < MIN_PERIOD) ? MIN_PERIOD : PERIOD;

  // cnt_q runs 0..P-1 across one whole period, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    rem_d   = rem_q;
    pulse_d = pulse_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef WHEEL_PULSE_GEN_SENT_CNT_EN
    sent_d  = sent_q;
`endif
    if (ABORT) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      per_d   = '0;
      rem_d   = '0;
      pulse_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            if (NUM_PULSES != '0) begin
              state_d = S_HIGH;
              cnt_d   = '0;
              per_d   = eff_period;
              rem_d   = NUM_PULSES;
              pulse_d = 1'b1;
              busy_d  = 1'b1;
`ifdef WHEEL_PULSE_GEN_SENT_CNT_EN
              // Clear and count the first rising edge in the same cycle.
              sent_d  = NUM_W'(1);
`endif
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_HIGH: begin
          cnt_d = cnt_q + PERIOD_W'(1);
          if (cnt_q == HIGH_LAST) begin
            state_d = S_LOW;
            pulse_d = 1'b0;
            rem_d   = rem_q - NUM_W'(1);
          end
        end
        S_LOW: begin
          if (cnt_q == per_q - PERIOD_W'(1)) begin
            cnt_d = '0;
            if (rem_q != '0) begin
              state_d = S_HIGH;
              pulse_d = 1'b1;
`ifdef WHEEL_PULSE_GEN_SENT_CNT_EN
              sent_d  = sent_q + NUM_W'(1);
`endif
            end else begin
              state_d = S_IDLE;
              per_d   = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          per_d   = '0;
          rem_d   = '0;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      rem_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef WHEEL_PULSE_GEN_SENT_CNT_EN
      sent_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      rem_q   <= rem_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef WHEEL_PULSE_GEN_SENT_CNT_EN
      sent_q  <= sent_d;
`endif
    end
  end

  assign PULSE = pulse_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
`ifdef WHEEL_PULSE_GEN_SENT_CNT_EN
  assign SENT_CNT = sent_q;
`endif

endmodule

// File: tb/tb_wheel_pulse_gen.sv
// Directed bench for wheel_pulse_gen; bit c of each trace vector is the output in cycle c (edge 0 = START edge).
module tb_wheel_pulse_gen;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic        ABORT;
  logic [15:0] PERIOD;
  logic [15:0] NUM_PULSES;
  logic        PULSE;
  logic        BUSY;
  logic        DONE;
`ifdef WHEEL_PULSE_GEN_SENT_CNT_EN
  logic [15:0] SENT_CNT;
`endif

  int n_chk = 0;
  int n_bad = 0;
  logic [63:0] vp, vb, vd;

  wheel_pulse_gen #(.PERIOD_W(16), .NUM_W(16), .HIGH_CYCLES(3)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .ABORT      (ABORT),
    .PERIOD     (PERIOD),
    .NUM_PULSES (NUM_PULSES),
    .PULSE      (PULSE),
    .BUSY       (BUSY),
    .DONE       (DONE)
`ifdef WHEEL_PULSE_GEN_SENT_CNT_EN
    ,
    .SENT_CNT   (SENT_CNT)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // START at edge 0 (and again at restart_at), ABORT at abort_at; PERIOD/NUM scrambled after edge 0.
  task automatic run(input logic [15:0] per, input logic [15:0] num,
                     input int abort_at, input int restart_at,
                     output logic [63:0] p, output logic [63:0] b, output logic [63:0] d);
    for (int c = 0; c < 64; c++) begin
      p[c] = PULSE;
      b[c] = BUSY;
      d[c] = DONE;
      START      = (c == 0) || (c == restart_at);
      ABORT      = (c == abort_at);
      PERIOD     = (c == 0) ? per : 16'd3;
      NUM_PULSES = (c == 0) ? num : 16'd1;
      tick();
    end
    START = 1'b0;
    ABORT = 1'b0;
  endtask

  function automatic int rises(input logic [63:0] v);
    int n = 0;
    for (int c = 1; c < 64; c++)
      if (v[c] && !v[c-1]) n++;
    return n;
  endfunction

  initial begin
    RESET      = 1'b1;
    START      = 1'b0;
    ABORT      = 1'b0;
    PERIOD     = 16'd0;
    NUM_PULSES = 16'd0;
    #12;
    chk("reset_outputs", {61'd0, PULSE, BUSY, DONE}, 64'd0);
    tick();
    RESET = 1'b0;
    tick();

    // Normal burst P=10, N=4.
    run(16'd10, 16'd4, -1, -1, vp, vb, vd);
    chk("normal_pulse", vp, 64'h0000_0003_80E0_380E);
    chk("normal_busy",  vb, 64'h0000_01FF_FFFF_FFFE);
    chk("normal_done",  vd, 64'h0000_0200_0000_0000);
    chk("normal_rises", 64'(rises(vp)), 64'd4);
`ifdef WHEEL_PULSE_GEN_SENT_CNT_EN
    chk("normal_sent", 64'(SENT_CNT), 64'd4);
`endif

    // Period clamp: PERIOD=2 becomes P=5.
    run(16'd2, 16'd3, -1, -1, vp, vb, vd);
    chk("clamp_pulse", vp, 64'h0000_0000_0000_39CE);
    chk("clamp_busy",  vb, 64'h0000_0000_0000_FFFE);
    chk("clamp_done",  vd, 64'h0000_0000_0001_0000);

    // Zero-length burst.
    run(16'd10, 16'd0, -1, -1, vp, vb, vd);
    chk("zero_pulse", vp, 64'd0);
    chk("zero_busy",  vb, 64'd0);
    chk("zero_done",  vd, 64'h2);

    // ABORT in cycle 15 (2nd LOW phase).
    run(16'd10, 16'd4, 15, -1, vp, vb, vd);
    chk("abort_pulse", vp, 64'h0000_0000_0000_380E);
    chk("abort_busy",  vb, 64'h0000_0000_0000_FFFE);
    chk("abort_done",  vd, 64'd0);
`ifdef WHEEL_PULSE_GEN_SENT_CNT_EN
    chk("abort_sent", 64'(SENT_CNT), 64'd2);
`endif

    // START while BUSY (with changed PERIOD/NUM) is ignored.
    run(16'd10, 16'd4, -1, 20, vp, vb, vd);
    chk("ign_pulse", vp, 64'h0000_0003_80E0_380E);
    chk("ign_busy",  vb, 64'h0000_01FF_FFFF_FFFE);
    chk("ign_done",  vd, 64'h0000_0200_0000_0000);

    // START and ABORT together in IDLE.
    run(16'd10, 16'd4, 0, -1, vp, vb, vd);
    chk("sa_pulse", vp, 64'd0);
    chk("sa_busy",  vb, 64'd0);
    chk("sa_done",  vd, 64'd0);

`ifdef WHEEL_PULSE_GEN_SENT_CNT_EN
    // ABORT after the 2nd rising edge (cycle 11).
    run(16'd10, 16'd4, 12, -1, vp, vb, vd);
    chk("abort2_rises", 64'(rises(vp)), 64'd2);
    chk("abort2_sent", 64'(SENT_CNT), 64'd2);
`endif

    // Async reset in the 2nd HIGH phase (cycle 12).
    PERIOD     = 16'd10;
    NUM_PULSES = 16'd4;
    START      = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    chk("pre_reset_pulse", {62'd0, PULSE, BUSY}, 64'h3);
    #2;
    RESET = 1'b1;
    #1;
    chk("async_reset", {61'd0, PULSE, BUSY, DONE}, 64'd0);
`ifdef WHEEL_PULSE_GEN_SENT_CNT_EN
    chk("reset_sent", 64'(SENT_CNT), 64'd0);
`endif
    tick();
    tick();
    RESET = 1'b0;
    tick();
    run(16'd10, 16'd4, -1, -1, vp, vb, vd);
    chk("post_reset_pulse", vp, 64'h0000_0003_80E0_380E);
    chk("post_reset_busy",  vb, 64'h0000_01FF_FFFF_FFFE);
    chk("post_reset_done",  vd, 64'h0000_0200_0000_0000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/wheel_pulse_gen.md
Name: wheel_pulse_gen

Overview:
- Transmitter counterpart to the odometer's wheel-pulse edge detector.
- Generates a programmed burst of clean rectangular wheel-tick pulses with a programmable period.
- Used as the on-chip wheel-sensor emulator for self-test and calibration. Its output feeds the edge-detector input directly.
- Pulse shape is guaranteed detectable: at least 1 high cycle, and at least 2 low cycles before every rising edge.

Parameters:
- PERIOD_W, 16: width of PERIOD and of the internal period counter.
- NUM_W, 16: width of NUM_PULSES and of the remaining-pulse counter.
- HIGH_CYCLES, 3: PULSE high width in clock cycles; legal range 1..(2^PERIOD_W - 3).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle burst request; sampled only when BUSY=0.
- ABORT  in  1  terminates any burst immediately.
- PERIOD  in  PERIOD_W  cycles from one rising edge to the next; latched at START.
- NUM_PULSES  in  NUM_W  pulses in the burst; latched at START.
- PULSE  out  1  registered wheel-tick output.
- BUSY  out  1  high while a burst is in progress.
- DONE  out  1  one-cycle strobe on normal burst completion.

Behaviour:
- Reset (async, RESET=1):
  - PULSE=0, BUSY=0, DONE=0.
  - State=IDLE; all counters cleared.
  - Release is synchronous to CLK.
- Effective period P = max(PERIOD, HIGH_CYCLES+2). Low width L = P - HIGH_CYCLES, which is always >= 2.
- State IDLE:
  - START=1 with ABORT=0 and NUM_PULSES != 0: latch P and NUM_PULSES, go to HIGH next edge. PULSE=1 and BUSY=1 in the first cycle after the START edge (1-cycle latency).
  - START=1 with NUM_PULSES=0: stay IDLE; DONE=1 for the next cycle; PULSE never rises.
  - START while BUSY=1 is ignored, with no queueing.
- State HIGH:
  - PULSE=1 for exactly HIGH_CYCLES cycles, then go to LOW.
  - The remaining-pulse count decrements on entry to LOW.
- State LOW:
  - PULSE=0 for exactly L cycles.
  - At the end of LOW: if remaining != 0, go to HIGH; else go to IDLE.
  - On the transition to IDLE, BUSY=0 and DONE=1 in the same cycle, for one cycle.
- Burst timing: BUSY is high for exactly NUM_PULSES*P cycles. DONE fires in cycle 1+NUM_PULSES*P relative to the START edge (edge 0).
- ABORT:
  - Any state: next cycle PULSE=0, BUSY=0, DONE=0, state=IDLE, counters cleared.
  - ABORT has priority over START in the same cycle.
  - An aborted HIGH phase may be shorter than HIGH_CYCLES. That is acceptable; the next burst still begins from IDLE, so it is preceded by at least 1 low cycle.
- Inputs: PERIOD and NUM_PULSES changes while BUSY=1 have no effect.
- Counters: the period counter never wraps, because it counts to at most P-1. NUM_PULSES at max (2^NUM_W - 1) must complete without overflow.
- No combinational path from any input to any output.

Optional Feature:
- Macro WHEEL_PULSE_GEN_SENT_CNT_EN.
- Defined:
  - Adds output SENT_CNT, NUM_W bits.
  - SENT_CNT increments on every rising edge of PULSE and wraps at 2^NUM_W.
  - Cleared by RESET and by START acceptance.
  - Not cleared by ABORT, so it holds the number of pulses actually emitted.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: RESET=1 mid-burst (PERIOD=10, NUM_PULSES=4, in the 2nd HIGH phase) -> PULSE, BUSY, DONE go 0 asynchronously; after release, a new START behaves normally.
- Normal burst: HIGH_CYCLES=3, PERIOD=10, NUM_PULSES=4, START at edge 0 -> PULSE high in cycles 1-3, 11-13, 21-23, 31-33, low otherwise; BUSY high cycles 1-40; DONE=1 only in cycle 41; 4 edge-detector DETECT pulses.
- Period clamp: PERIOD=2, NUM_PULSES=3 -> P=5; PULSE high 3 cycles, low 2 cycles, repeated 3 times; DONE in cycle 16.
- Zero burst: NUM_PULSES=0, START -> PULSE stays 0, BUSY stays 0, DONE=1 in cycle 1.
- ABORT and START ignore:
  - ABORT during the 2nd LOW phase -> next cycle BUSY=0, PULSE=0, no DONE.
  - START during BUSY -> ignored.
  - START and ABORT together in IDLE -> nothing starts.
- With WHEEL_PULSE_GEN_SENT_CNT_EN: burst of 4 -> SENT_CNT=4; START then ABORT after 2 rising edges -> SENT_CNT holds 2.
